reciprocal_iter: RTL and testbench



---
 rtl/reciprocal_iter_if.sv | 57 +++++
 rtl/reciprocal_iter.sv | 186 ++++++++++++++++++
 tb/tb_reciprocal_iter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/reciprocal_iter_if.sv
// ----------------------------------------------------------------------------
// reciprocal_iter_if
//
// Purpose:
//   Groups the request/response handshake of the reciprocal unit so the
//   producer/consumer side and the divider share one bundle.
//
// Signals:
//   in_valid    request present (master -> slave)
//   in_ready    unit can accept a request (slave -> master)
//   num         unsigned divisor, WIDTH bits (master -> slave)
//   out_valid   result available (slave -> master)
//   out_ready   consumer takes the result (master -> slave)
//   reciprocal  unsigned quotient, WIDTH bits (slave -> master)
//   div_by_zero result came from a zero divisor (slave -> master)
//   busy        unit is working on or holding a result (slave -> master)
//
// Modports:
//   master  the requester/consumer side
//   slave   the reciprocal unit itself
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

interface reciprocal_iter_if #(
    parameter int WIDTH = 27
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] num;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] reciprocal;
    logic             div_by_zero;
    logic             busy;

    modport master (
        output in_valid,
        output num,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  reciprocal,
        input  div_by_zero,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  num,
        input  out_ready,
        output in_ready,
        output out_valid,
        output reciprocal,
        output div_by_zero,
        output busy
    );
endinterface

// File: rtl/reciprocal_iter.sv
// ----------------------------------------------------------------------------
// reciprocal_iter
//
// Purpose:
//   Multi-cycle fixed-point reciprocal. Computes floor(2^FRAC / num) with a
//   radix-2 restoring division producing one quotient bit per clock. A zero
//   divisor is reported through div_by_zero with an all-ones result.
//
// Parameters:
//   WIDTH  bit width of num and of the result
//   FRAC   fractional bits of the result, 1 <= FRAC <= WIDTH-1
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    reciprocal_iter_if.slave: in_valid/in_ready/num request side,
//          out_valid/out_ready/reciprocal/div_by_zero response side, busy
//
// Build option:
//   RECIP_ROUND_EN  when defined, a ROUND state after the iterations turns
//                   the truncated quotient into round-half-up of 2^FRAC/num
//                   (one extra cycle of latency).
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module reciprocal_iter #(
    parameter int WIDTH = 27,
    parameter int FRAC  = 26
) (
    input logic              clk,
    input logic              rst_n,
    reciprocal_iter_if.slave bus
);

    // A FRAC outside 1..WIDTH-1 would let the quotient overflow WIDTH bits,
    // so such a configuration is refused at elaboration.
    generate
        if (FRAC < 1 || FRAC > WIDTH - 1) begin : gBadFrac
            $error("reciprocal_iter: FRAC must satisfy 1 <= FRAC <= WIDTH-1");
        end
    endgenerate

    localparam int               CNT_W    = $clog2(FRAC + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FRAC);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_DONE  = 2'd2
`ifdef RECIP_ROUND_EN
        ,
        S_ROUND = 2'd3
`endif
    } state_t;

    state_t           state_q,     state_d;
    logic [WIDTH-1:0] divisor_q,   divisor_d;
    logic [WIDTH:0]   remainder_q, remainder_d;
    logic [WIDTH-1:0] quotient_q,  quotient_d;
    logic [CNT_W-1:0] count_q,     count_d;
    logic [WIDTH-1:0] result_q,    result_d;
    logic             divZero_q,   divZero_d;

    logic [WIDTH:0]   shiftedRem;
    logic             geDivisor;
    logic [WIDTH:0]   diffRem;
    logic [WIDTH-1:0] quotientStep;
`ifdef RECIP_ROUND_EN
    logic             roundUp;
`endif

    // One restoring-division step. The very first iteration (counter still at
    // its start value) compares the initial remainder of 1 directly, which
    // produces the 2^FRAC quotient bit; every later step doubles the
    // remainder first. Because the remainder always stays below the divisor,
    // the doubled value fits in WIDTH+1 bits.
    always_comb begin
        shiftedRem   = (count_q == CNT_INIT) ? remainder_q : (remainder_q << 1);
        geDivisor    = (shiftedRem >= {1'b0, divisor_q});
        diffRem      = shiftedRem - {1'b0, divisor_q};
        quotientStep = (quotient_q << 1) | WIDTH'(geDivisor);
`ifdef RECIP_ROUND_EN
        roundUp      = ((remainder_q << 1) >= {1'b0, divisor_q});
`endif
    end

    // Next-state and datapath control. Everything holds by default; the
    // result register only changes on the way into DONE so the consumer sees
    // a stable value while it stalls and after it has taken the result.
    always_comb begin
        state_d     = state_q;
        divisor_d   = divisor_q;
        remainder_d = remainder_q;
        quotient_d  = quotient_q;
        count_d     = count_q;
        result_d    = result_q;
        divZero_d   = divZero_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    divisor_d = bus.num;
                    if (bus.num == '0) begin
                        state_d   = S_DONE;
                        result_d  = '1;
                        divZero_d = 1'b1;
                    end else begin
                        state_d     = S_CALC;
                        remainder_d = (WIDTH+1)'(1);
                        quotient_d  = '0;
                        count_d     = CNT_INIT;
                        divZero_d   = 1'b0;
                    end
                end
            end

            S_CALC: begin
                remainder_d = geDivisor ? diffRem : shiftedRem;
                quotient_d  = quotientStep;
                if (count_q == '0) begin
`ifdef RECIP_ROUND_EN
                    state_d  = S_ROUND;
`else
                    state_d  = S_DONE;
                    result_d = quotientStep;
`endif
                end else begin
                    count_d = count_q - 1'b1;
                end
            end

`ifdef RECIP_ROUND_EN
            S_ROUND: begin
                state_d = S_DONE;
                if (roundUp && (quotient_q != '1)) begin
                    result_d = quotient_q + 1'b1;
                end else begin
                    result_d = quotient_q;
                end
            end
`endif

            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset drops any in-flight division on
    // the spot, so a reset mid-calculation emits nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            divisor_q   <= '0;
            remainder_q <= '0;
            quotient_q  <= '0;
            count_q     <= '0;
            result_q    <= '0;
            divZero_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            divisor_q   <= divisor_d;
            remainder_q <= remainder_d;
            quotient_q  <= quotient_d;
            count_q     <= count_d;
            result_q    <= result_d;
            divZero_q   <= divZero_d;
        end
    end

    // Handshake flags are pure decodes of the state, so in_ready and
    // out_valid can never be high together and there is no overlap between
    // consecutive requests.
    assign bus.in_ready    = (state_q == S_IDLE);
    assign bus.out_valid   = (state_q == S_DONE);
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.reciprocal  = result_q;
    assign bus.div_by_zero = divZero_q;

endmodule

// File: tb/tb_reciprocal_iter.sv
// ----------------------------------------------------------------------------
// tb_reciprocal_iter
//
// Purpose:
//   Self-checking bench for reciprocal_iter (WIDTH=27, FRAC=26). Expected
//   quotients and latencies come from plain integer arithmetic on 2^FRAC/num.
//   Honours RECIP_ROUND_EN the same way the design does.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_reciprocal_iter;

    localparam int WIDTH = 27;
    localparam int FRAC  = 26;
    localparam longint unsigned MAXV = (64'd1 << WIDTH) - 64'd1;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    reciprocal_iter_if #(.WIDTH(WIDTH)) bus ();

    reciprocal_iter #(
        .WIDTH(WIDTH),
        .FRAC (FRAC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference quotient straight from the arithmetic definition.
    function automatic longint unsigned modelRecip(input longint unsigned n);
        longint unsigned q;
        if (n == 0) begin
            return MAXV;
        end
`ifdef RECIP_ROUND_EN
        q = ((64'd1 << (FRAC + 1)) + n) / (64'd2 * n);
`else
        q = (64'd1 << FRAC) / n;
`endif
        if (q > MAXV) begin
            q = MAXV;
        end
        return q;
    endfunction

    // Edges from accept (counted as the first) until out_valid is seen.
    function automatic int modelLatency(input longint unsigned n);
        if (n == 0) begin
            return 1;
        end
`ifdef RECIP_ROUND_EN
        return FRAC + 3;
`else
        return FRAC + 2;
`endif
    endfunction

    // Single comparison point: counts the check and reports any miss.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Issues one request, waits (bounded) for the result, checks it, and
    // optionally stalls the consumer for a few cycles while num toggles and
    // in_valid stays high before completing the output handshake.
    task automatic applyStimulus(input logic [WIDTH-1:0] n, input int stall);
        longint unsigned expQ;
        int              expLat;
        int              edges;
        expQ   = modelRecip(64'(n));
        expLat = modelLatency(64'(n));

        @(negedge clk);
        checkOutput("ready_before_accept", 64'(bus.in_ready), 64'd1);
        bus.in_valid  = 1'b1;
        bus.num       = n;
        bus.out_ready = (stall == 0);

        @(posedge clk);
        #1;
        edges = 1;
        if (stall == 0) begin
            bus.in_valid = 1'b0;
        end
        bus.num = WIDTH'($urandom);
        checkOutput("busy_after_accept", 64'({bus.busy, bus.in_ready}), 64'b10);

        while (!bus.out_valid && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
            bus.num = WIDTH'($urandom);
        end
        checkOutput("latency", 64'(edges), 64'(expLat));
        checkOutput("reciprocal", 64'(bus.reciprocal), expQ);
        checkOutput("div_by_zero", 64'(bus.div_by_zero), 64'(n == '0));

        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            bus.num = WIDTH'($urandom);
            checkOutput("stall_hold",
                        64'({bus.out_valid, bus.in_ready, bus.div_by_zero, bus.reciprocal}),
                        {34'd0, 1'b1, 1'b0, (n == '0), WIDTH'(expQ)});
        end
        bus.out_ready = 1'b1;

        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        checkOutput("after_handshake",
                    64'({bus.out_valid, bus.in_ready, bus.busy, bus.reciprocal}),
                    {35'd0, 1'b0, 1'b1, 1'b0, WIDTH'(expQ)});
    endtask

    // Linear sequence of directed and randomized steps.
    initial begin
        logic [WIDTH-1:0] rn;
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.num       = '0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        $display("[TB] reset released");

        // Idle after reset: nothing moves for 50 cycles.
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            checkOutput("idle_after_reset",
                        64'({bus.in_ready, bus.out_valid, bus.busy, bus.div_by_zero, bus.reciprocal}),
                        {33'd0, 1'b1, 1'b0, 1'b0, 1'b0, WIDTH'(0)});
        end

        // Directed corner values.
        applyStimulus(27'd1, 0);
        applyStimulus(27'd6, 0);
        applyStimulus(27'h7FFFFFF, 0);
        applyStimulus(27'd0, 0);
        applyStimulus(27'd3, 10);
        applyStimulus(27'd2, 0);
        applyStimulus(27'h4000000, 3);

        // Randomized divisors: small, full-range and occasional zero.
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0:       rn = WIDTH'($urandom_range(1, 255));
                1:       rn = WIDTH'($urandom_range(0, 3));
                default: rn = WIDTH'($urandom);
            endcase
            applyStimulus(rn, int'($urandom_range(0, 3)));
        end

        // Reset in the middle of a calculation.
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.num       = 27'd5;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset",
                    64'({bus.in_ready, bus.out_valid, bus.busy, bus.div_by_zero, bus.reciprocal}),
                    {33'd0, 1'b1, 1'b0, 1'b0, 1'b0, WIDTH'(0)});
        repeat (2) @(posedge clk);
        #1;
        checkOutput("held_in_reset", 64'({bus.out_valid, bus.busy}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("no_emit_after_reset", 64'({bus.out_valid, bus.in_ready}), 64'b01);
        applyStimulus(27'h4000000, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
